// File: rtl/corelet_ctrl.sv
// corelet_ctrl: sequencer for one corelet run of len_kij kernel positions.
// For each kernel position k it loads a weight tile into L0, moves it into
// the PE array, waits for it to settle, streams len_nij activation vectors
// through L0 into the array, then drains the OFIFO into psum SRAM.
//
// Ports
//   clk          single clock, rising edge
//   reset        synchronous active-high reset
//   start        begin a run (honoured only when idle)
//   relu_en      relu flag, captured at start, drives inst[34] for the run
//   ofifo_valid  OFIFO holds at least one complete row
//   inst[36:0]   corelet instruction word (0 load, 1 execute, 2 l0_wr,
//                3 l0_rd, 6 ofifo_rd, 34 relu; all other bits 0)
//   xmem_cen     activation/weight SRAM chip enable, active-low
//   xmem_addr    activation/weight SRAM read address
//   pmem_wen     psum SRAM write enable, active-low
//   pmem_addr    psum SRAM write address
//   busy         high while a run is in progress (not IDLE, not DONE)
//   done         one-cycle pulse when the run completes
module corelet_ctrl #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int len_kij = 9,
  parameter int len_nij = 36,
  parameter int addr_bw = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               relu_en,
  input  logic               ofifo_valid,
  output logic [36:0]        inst,
  output logic               xmem_cen,
  output logic [addr_bw-1:0] xmem_addr,
  output logic               pmem_wen,
  output logic [addr_bw-1:0] pmem_addr,
  output logic               busy,
  output logic               done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WLOAD = 3'd1;
  localparam logic [2:0] S_KLOAD = 3'd2;
  localparam logic [2:0] S_KWAIT = 3'd3;
  localparam logic [2:0] S_ALOAD = 3'd4;
  localparam logic [2:0] S_EXEC  = 3'd5;
  localparam logic [2:0] S_DRAIN = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  // Phase counter must reach the longest phase length without wrapping.
  localparam int CMAX = ((col + 1) > (row + col))
                        ? (((col + 1) > (len_nij + 1)) ? (col + 1) : (len_nij + 1))
                        : (((row + col) > (len_nij + 1)) ? (row + col) : (len_nij + 1));
  localparam int CW = $clog2(CMAX + 1);
  localparam int KW = $clog2(len_kij + 1);
  localparam int RW = $clog2(len_nij + 1);

  localparam logic [CW-1:0] WL_END = CW'(col);
  localparam logic [CW-1:0] KL_END = CW'(col - 1);
  localparam logic [CW-1:0] KW_END = CW'(row + col - 1);
  localparam logic [CW-1:0] AL_END = CW'(len_nij);
  localparam logic [CW-1:0] EX_END = CW'(len_nij - 1);
  localparam logic [RW-1:0] RD_END = RW'(len_nij);
  localparam logic [KW-1:0] K_LAST = KW'(len_kij - 1);

  logic [2:0]    state_r, nstate_s;
  logic [CW-1:0] cnt_r, ncnt_s;
  logic [KW-1:0] k_r, nk_s;
  logic [RW-1:0] rd_r, nrd_s;
  logic          relu_r, nrelu_s;
  logic          rd_s;

  logic          load_r, exec_r, l0_wr_r, l0_rd_r, relu_out_r;
  logic          n_load_s, n_exec_s, n_l0_wr_s, n_l0_rd_s, n_relu_s;
  logic          n_xcen_s, n_pwen_s, n_busy_s, n_done_s;
  logic [addr_bw-1:0] n_xaddr_s, n_paddr_s;

  // OFIFO read is combinational so it never fires on a cycle where the
  // FIFO has nothing to give.
  assign rd_s = (state_r == S_DRAIN) && ofifo_valid && (rd_r < RD_END);

  assign inst = {2'b00, relu_out_r, 27'd0, rd_s, 2'b00,
                 l0_rd_r, l0_wr_r, exec_r, load_r};

  // Next-state and phase-counter logic.
  always_comb begin
    nstate_s = state_r;
    ncnt_s   = cnt_r;
    nk_s     = k_r;
    nrd_s    = rd_r;
    nrelu_s  = relu_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          nstate_s = S_WLOAD;
          ncnt_s   = {CW{1'b0}};
          nk_s     = {KW{1'b0}};
          nrd_s    = {RW{1'b0}};
          nrelu_s  = relu_en;
        end else begin
          nstate_s = S_IDLE;
        end
      end
      S_WLOAD: begin
        // col reads plus one trailing cycle for the last l0_wr
        if (cnt_r == WL_END) begin
          nstate_s = S_KLOAD;
          ncnt_s   = {CW{1'b0}};
        end else begin
          ncnt_s = cnt_r + CW'(1);
        end
      end
      S_KLOAD: begin
        if (cnt_r == KL_END) begin
          nstate_s = S_KWAIT;
          ncnt_s   = {CW{1'b0}};
        end else begin
          ncnt_s = cnt_r + CW'(1);
        end
      end
      S_KWAIT: begin
        if (cnt_r == KW_END) begin
          nstate_s = S_ALOAD;
          ncnt_s   = {CW{1'b0}};
        end else begin
          ncnt_s = cnt_r + CW'(1);
        end
      end
      S_ALOAD: begin
        if (cnt_r == AL_END) begin
          nstate_s = S_EXEC;
          ncnt_s   = {CW{1'b0}};
        end else begin
          ncnt_s = cnt_r + CW'(1);
        end
      end
      S_EXEC: begin
        if (cnt_r == EX_END) begin
          nstate_s = S_DRAIN;
          ncnt_s   = {CW{1'b0}};
          nrd_s    = {RW{1'b0}};
        end else begin
          ncnt_s = cnt_r + CW'(1);
        end
      end
      S_DRAIN: begin
        // Leave only once the write that follows the last read is on the bus.
        if ((rd_r == RD_END) && !pmem_wen) begin
          ncnt_s = {CW{1'b0}};
          if (k_r == K_LAST) begin
            nstate_s = S_DONE;
          end else begin
            nstate_s = S_WLOAD;
            nk_s     = k_r + KW'(1);
          end
        end else if (rd_s) begin
          nrd_s = rd_r + RW'(1);
        end else begin
          nrd_s = rd_r;
        end
      end
      S_DONE: begin
        nstate_s = S_IDLE;
      end
      default: begin
        nstate_s = S_IDLE;
      end
    endcase
  end

  // Output values for the next cycle, derived from the next state.
  always_comb begin
    n_load_s  = (nstate_s == S_KLOAD);
    n_exec_s  = (nstate_s == S_EXEC);
    n_l0_rd_s = (nstate_s == S_KLOAD) || (nstate_s == S_EXEC);
    n_l0_wr_s = ((nstate_s == S_WLOAD) || (nstate_s == S_ALOAD))
                && (ncnt_s != {CW{1'b0}});
    n_busy_s  = (nstate_s != S_IDLE) && (nstate_s != S_DONE);
    n_done_s  = (nstate_s == S_DONE);
    n_relu_s  = n_busy_s && nrelu_s;
    n_xcen_s  = 1'b1;
    n_xaddr_s = xmem_addr;
    if ((nstate_s == S_WLOAD) && (ncnt_s < WL_END)) begin
      n_xcen_s  = 1'b0;
      n_xaddr_s = addr_bw'(nk_s) * addr_bw'(col) + addr_bw'(ncnt_s);
    end else if ((nstate_s == S_ALOAD) && (ncnt_s < AL_END)) begin
      n_xcen_s  = 1'b0;
      n_xaddr_s = addr_bw'(len_kij) * addr_bw'(col) + addr_bw'(ncnt_s);
    end else begin
      n_xcen_s  = 1'b1;
      n_xaddr_s = xmem_addr;
    end
    if (rd_s) begin
      n_pwen_s  = 1'b0;
      n_paddr_s = addr_bw'(k_r) * addr_bw'(len_nij) + addr_bw'(rd_r);
    end else begin
      n_pwen_s  = 1'b1;
      n_paddr_s = pmem_addr;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_IDLE;
      cnt_r      <= {CW{1'b0}};
      k_r        <= {KW{1'b0}};
      rd_r       <= {RW{1'b0}};
      relu_r     <= 1'b0;
      load_r     <= 1'b0;
      exec_r     <= 1'b0;
      l0_wr_r    <= 1'b0;
      l0_rd_r    <= 1'b0;
      relu_out_r <= 1'b0;
      xmem_cen   <= 1'b1;
      xmem_addr  <= {addr_bw{1'b0}};
      pmem_wen   <= 1'b1;
      pmem_addr  <= {addr_bw{1'b0}};
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_r    <= nstate_s;
      cnt_r      <= ncnt_s;
      k_r        <= nk_s;
      rd_r       <= nrd_s;
      relu_r     <= nrelu_s;
      load_r     <= n_load_s;
      exec_r     <= n_exec_s;
      l0_wr_r    <= n_l0_wr_s;
      l0_rd_r    <= n_l0_rd_s;
      relu_out_r <= n_relu_s;
      xmem_cen   <= n_xcen_s;
      xmem_addr  <= n_xaddr_s;
      pmem_wen   <= n_pwen_s;
      pmem_addr  <= n_paddr_s;
      busy       <= n_busy_s;
      done       <= n_done_s;
    end
  end

endmodule

// File: tb/tb_corelet_ctrl.sv
// Bench for corelet_ctrl. A run is described as a table of per-cycle
// records {stimulus, expected outputs}, built from the phase lengths and
// address formulas of a run; the table is then applied and compared cycle by
// cycle. dut_a uses default parameters, dut_b uses len_kij=1, len_nij=1.
module tb_corelet_ctrl;

  typedef struct {
    logic        st;
    logic        v;
    logic        re;
    logic        xcen;
    logic [10:0] xa;
    logic        pwen;
    logic [10:0] pa;
    logic [6:0]  i7;
    logic        relu;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t tr[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_a = 1'b0, relu_a = 1'b0, valid_a = 1'b0;
  logic start_b = 1'b0, relu_b = 1'b0, valid_b = 1'b0;
  logic [36:0] inst_a, inst_b;
  logic xcen_a, xcen_b, pwen_a, pwen_b, busy_a, busy_b, done_a, done_b;
  logic [10:0] xa_a, xa_b, pa_a, pa_b;
  logic [10:0] ma_xa, ma_pa, mb_xa, mb_pa;

  always #5 clk = ~clk;

  corelet_ctrl dut_a (
    .clk(clk), .reset(reset), .start(start_a), .relu_en(relu_a),
    .ofifo_valid(valid_a), .inst(inst_a), .xmem_cen(xcen_a),
    .xmem_addr(xa_a), .pmem_wen(pwen_a), .pmem_addr(pa_a),
    .busy(busy_a), .done(done_a)
  );

  corelet_ctrl #(.len_kij(1), .len_nij(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .relu_en(relu_b),
    .ofifo_valid(valid_b), .inst(inst_b), .xmem_cen(xcen_b),
    .xmem_addr(xa_b), .pmem_wen(pwen_b), .pmem_addr(pa_b),
    .busy(busy_b), .done(done_b)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic rb(input int n);
    return ($urandom_range(0, n - 1) == 0);
  endfunction

  function automatic void push(input logic st, input logic v, input logic re,
                               input logic xcen, input logic [10:0] xa,
                               input logic pwen, input logic [10:0] pa,
                               input logic [6:0] i7, input logic relu,
                               input logic busy, input logic done);
    vec_t e;
    e.st = st; e.v = v; e.re = re; e.xcen = xcen; e.xa = xa; e.pwen = pwen;
    e.pa = pa; e.i7 = i7; e.relu = relu; e.busy = busy; e.done = done;
    tr.push_back(e);
  endfunction

  // Expected trace of one run. mode: 0 ofifo_valid tied 1, 1 toggling, 2 random.
  task automatic build(input int rr, input int cc, input int kk, input int nn,
                       input int mode, input logic relu0,
                       input logic [10:0] xa0, input logic [10:0] pa0,
                       output logic [10:0] xa1, output logic [10:0] pa1);
    logic [10:0] xa, pa;
    logic rdp, rd, wr, v;
    int r, w, ph;
    xa = xa0;
    pa = pa0;
    tr.delete();
    push(1'b1, rb(2), relu0, 1'b1, xa, 1'b1, pa, 7'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < kk; k++) begin
      for (int j = 0; j <= cc; j++) begin
        if (j < cc) xa = 11'(k * cc + j);
        push(rb(4), rb(2), rb(2), (j >= cc), xa, 1'b1, pa,
             (j >= 1) ? 7'b0000100 : 7'b0000000, relu0, 1'b1, 1'b0);
      end
      for (int j = 0; j < cc; j++)
        push(rb(4), rb(2), rb(2), 1'b1, xa, 1'b1, pa, 7'b0001001, relu0, 1'b1, 1'b0);
      for (int j = 0; j < rr + cc; j++)
        push(rb(4), rb(2), rb(2), 1'b1, xa, 1'b1, pa, 7'b0000000, relu0, 1'b1, 1'b0);
      for (int j = 0; j <= nn; j++) begin
        if (j < nn) xa = 11'(kk * cc + j);
        push(rb(4), rb(2), rb(2), (j >= nn), xa, 1'b1, pa,
             (j >= 1) ? 7'b0000100 : 7'b0000000, relu0, 1'b1, 1'b0);
      end
      for (int j = 0; j < nn; j++)
        push(rb(4), rb(2), rb(2), 1'b1, xa, 1'b1, pa, 7'b0001010, relu0, 1'b1, 1'b0);
      r = 0; w = 0; rdp = 1'b0; ph = 0;
      do begin
        wr = rdp;
        if (wr) begin
          pa = 11'(k * nn + w);
          w++;
        end
        v  = (mode == 0) ? 1'b1 : (mode == 1) ? ((ph % 2) == 0) : !rb(3);
        ph++;
        rd = v && (r < nn);
        if (rd) r++;
        push(rb(4), v, rb(2), 1'b1, xa, !wr, pa, {rd, 6'b0}, relu0, 1'b1, 1'b0);
        rdp = rd;
      end while (!(wr && (w == nn)));
    end
    push(rb(2), rb(2), rb(2), 1'b1, xa, 1'b1, pa, 7'd0, 1'b0, 1'b0, 1'b1);
    push(1'b0, rb(2), rb(2), 1'b1, xa, 1'b1, pa, 7'd0, 1'b0, 1'b0, 1'b0);
    xa1 = xa;
    pa1 = pa;
  endtask

  task automatic drive(input int sel, input logic st, input logic v, input logic re);
    if (sel == 0) begin
      start_a = st; valid_a = v; relu_a = re;
    end else begin
      start_b = st; valid_b = v; relu_b = re;
    end
  endtask

  // Apply the current table to one DUT and compare every cycle.
  task automatic run_trace(input int sel, input int exp_writes);
    logic [36:0] oi;
    logic [10:0] oxa, opa;
    logic oxc, opw, obs, odn;
    int nw;
    nw = 0;
    for (int c = 0; c < tr.size(); c++) begin
      @(posedge clk);
      #1;
      cyc = c;
      drive(sel, tr[c].st, tr[c].v, tr[c].re);
      @(negedge clk);
      if (sel == 0) begin
        oi = inst_a; oxc = xcen_a; oxa = xa_a; opw = pwen_a; opa = pa_a; obs = busy_a; odn = done_a;
      end else begin
        oi = inst_b; oxc = xcen_b; oxa = xa_b; opw = pwen_b; opa = pa_b; obs = busy_b; odn = done_b;
      end
      if (!opw) nw++;
      chk("inst", 64'(oi), 64'({2'b00, tr[c].relu, 27'd0, tr[c].i7}));
      chk("xmem_cen", 64'(oxc), 64'(tr[c].xcen));
      chk("xmem_addr", 64'(oxa), 64'(tr[c].xa));
      chk("pmem_wen", 64'(opw), 64'(tr[c].pwen));
      chk("pmem_addr", 64'(opa), 64'(tr[c].pa));
      chk("busy", 64'(obs), 64'(tr[c].busy));
      chk("done", 64'(odn), 64'(tr[c].done));
    end
    drive(sel, 1'b0, 1'b0, 1'b0);
    chk("pmem_writes", 64'(nw), 64'(exp_writes));
  endtask

  task automatic chk_idle_a(input string nm);
    chk({nm, "_inst"}, 64'(inst_a), 64'd0);
    chk({nm, "_xcen"}, 64'(xcen_a), 64'd1);
    chk({nm, "_pwen"}, 64'(pwen_a), 64'd1);
    chk({nm, "_busy"}, 64'(busy_a), 64'd0);
    chk({nm, "_done"}, 64'(done_a), 64'd0);
  endtask

  initial begin
    int execs;
    logic prev_exec;
    logic relu0;

    // Reset values
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cyc = 0;
    chk_idle_a("rst_a");
    chk("rst_xaddr_a", 64'(xa_a), 64'd0);
    chk("rst_paddr_a", 64'(pa_a), 64'd0);
    chk("rst_busy_b", 64'(busy_b), 64'd0);
    chk("rst_xcen_b", 64'(xcen_b), 64'd1);
    ma_xa = 11'd0; ma_pa = 11'd0; mb_xa = 11'd0; mb_pa = 11'd0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Full run, ofifo_valid tied high, relu on
    build(8, 8, 9, 36, 0, 1'b1, ma_xa, ma_pa, ma_xa, ma_pa);
    run_trace(0, 324);

    // ofifo_valid toggling every cycle in DRAIN, relu off
    build(8, 8, 9, 36, 1, 1'b0, ma_xa, ma_pa, ma_xa, ma_pa);
    run_trace(0, 324);

    // Reset during EXEC of kij 3 aborts the run
    @(posedge clk);
    #1;
    start_a = 1'b1; valid_a = 1'b1; relu_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    execs = 0;
    prev_exec = 1'b0;
    for (int t = 0; t < 4000 && execs < 4; t++) begin
      @(negedge clk);
      if (inst_a[1] && !prev_exec) execs++;
      prev_exec = inst_a[1];
    end
    chk("exec_k3_reached", 64'(execs), 64'd4);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    valid_a = 1'b0;
    @(negedge clk);
    chk_idle_a("abort");
    chk("abort_xaddr", 64'(xa_a), 64'd0);
    chk("abort_paddr", 64'(pa_a), 64'd0);
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      chk_idle_a("post_abort");
    end
    ma_xa = 11'd0; ma_pa = 11'd0; mb_xa = 11'd0; mb_pa = 11'd0;

    // Restart after abort, random ofifo_valid
    relu0 = rb(2);
    build(8, 8, 9, 36, 2, relu0, ma_xa, ma_pa, ma_xa, ma_pa);
    run_trace(0, 324);

    // Minimal run: len_kij=1, len_nij=1
    build(8, 8, 1, 1, 0, 1'b1, mb_xa, mb_pa, mb_xa, mb_pa);
    run_trace(1, 1);
    build(8, 8, 1, 1, 2, 1'b0, mb_xa, mb_pa, mb_xa, mb_pa);
    run_trace(1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/corelet_ctrl.md
CORELET_CTRL -- requirements
Module: corelet_ctrl

Interface
REQ-001 SHALL have parameter row, 8, number of PE rows (L0 lanes).
REQ-002 SHALL have parameter col, 8, number of PE columns (OFIFO lanes).
REQ-003 SHALL have parameter len_kij, 9, kernel positions per run.
REQ-004 SHALL have parameter len_nij, 36, activation vectors per kernel position.
REQ-005 SHALL have parameter addr_bw, 11, SRAM address width.
REQ-006 SHALL have port clk input 1: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset input 1: synchronous, active-high reset.
REQ-008 SHALL have port start input 1: one-cycle request to begin a run; honoured only in IDLE.
REQ-009 SHALL have port relu_en input 1: sampled at start, drives inst[34] for the whole run.
REQ-010 SHALL have port ofifo_valid input 1: OFIFO holds at least one complete output row.
REQ-011 SHALL have port inst output 37: corelet instruction word (bit 0 load, 1 execute, 2 l0_wr, 3 l0_rd, 6 ofifo_rd, 34 relu; bits 4, 5, 33, 35, 36 and 7..32 tied 0).
REQ-012 SHALL have port xmem_cen output 1: activation/weight SRAM chip enable, active-low.
REQ-013 SHALL have port xmem_addr output addr_bw: activation/weight SRAM read address.
REQ-014 SHALL have port pmem_wen output 1: psum SRAM write enable, active-low.
REQ-015 SHALL have port pmem_addr output addr_bw: psum SRAM write address.
REQ-016 SHALL have port busy output 1: high in every state except IDLE and DONE.
REQ-017 SHALL have port done output 1: one-cycle pulse when the run completes.

Function
REQ-018 SHALL implement states IDLE, WLOAD, KLOAD, KWAIT, ALOAD, EXEC, DRAIN, DONE; IDLE->WLOAD on start.
REQ-019 WLOAD SHALL issue col SRAM reads (xmem_cen=0) at xmem_addr = k*col + i, i=0..col-1, k = current kij index.
REQ-020 SRAM read latency is 1 cycle: inst[2] (l0_wr) SHALL be asserted exactly one cycle after each read, so the state exits after col+1 cycles.
REQ-021 KLOAD SHALL assert inst[3] and inst[0] together for col cycles, then go to KWAIT.
REQ-022 KWAIT SHALL hold inst[3:0]=0 for row+col cycles (weight propagation), then go to ALOAD.
REQ-023 ALOAD SHALL read xmem_addr = len_kij*col + n, n=0..len_nij-1, with l0_wr one cycle delayed as in REQ-020, then go to EXEC.
REQ-024 EXEC SHALL assert inst[3] and inst[1] for len_nij cycles, then go to DRAIN.
REQ-025 DRAIN SHALL assert inst[6] in each cycle where ofifo_valid=1 and fewer than len_nij rows have been read; inst[6]=0 otherwise.
REQ-026 For each ofifo_rd, pmem_wen SHALL be 0 in the following cycle with pmem_addr = k*len_nij + r, r = read index 0..len_nij-1.
REQ-027 After the last pmem write of kij k: if k < len_kij-1, increment k and go to WLOAD; else go to DONE.
REQ-028 DONE SHALL last one cycle with done=1, then return to IDLE; start in any non-IDLE state is ignored.
REQ-029 Outside their states, xmem_cen and pmem_wen SHALL be 1 and inst[6:0] SHALL be 0; addresses hold their last value.
REQ-030 Counters SHALL be sized for len_kij, len_nij, row+col without wrap; address arithmetic is unsigned modulo 2^addr_bw.
REQ-031 ofifo_valid deasserting mid-DRAIN SHALL stall reads without losing count; no timeout.

Reset
REQ-032 reset=1 SHALL, at the next edge, force IDLE, clear all counters and k, set inst=0, xmem_cen=1, pmem_wen=1, xmem_addr=0, pmem_addr=0, busy=0, done=0.
REQ-033 reset SHALL take priority over start and abort any run in progress with no further SRAM access.

Verification
REQ-034 Reset then start with defaults -> WLOAD reads addrs 0..7, l0_wr high cycles 2..9 after start-accept, busy=1.
REQ-035 Full run with ofifo_valid tied 1 -> 9 iterations, 324 pmem writes to addrs 0..323 in order, single done pulse, busy=0 after.
REQ-036 ofifo_valid toggling 1/0 each cycle in DRAIN -> exactly 36 ofifo_rd per kij, pmem_wen lows never back-to-back, addresses contiguous.
REQ-037 reset asserted during EXEC of k=3 -> next cycle inst=0, xmem_cen=1, IDLE; new start restarts at xmem_addr 0.
REQ-038 start pulsed during KWAIT and DRAIN -> no effect; relu_en changed mid-run -> inst[34] keeps the value sampled at start.
REQ-039 Parameters len_kij=1, len_nij=1 -> KLOAD 8 cycles, KWAIT 16 cycles, one pmem write at addr 0, done.
